// File: rtl/div_unit_if.sv
// ES-stage <-> divider bundle: operands and control from the pipeline,
// stall request and results back.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             es_valid;
  logic             es_div_op;
  logic             es_div_signed;
  logic [WIDTH-1:0] es_src1;
  logic [WIDTH-1:0] es_src2;
  logic             es_go;
  logic             ex_flush;
  logic             div_block;
  logic             div_done;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] div_hi;

  modport master (
    output es_valid, es_div_op, es_div_signed, es_src1, es_src2, es_go, ex_flush,
    input  div_block, div_done, div_lo, div_hi
  );

  modport slave (
    input  es_valid, es_div_op, es_div_signed, es_src1, es_src2, es_go, ex_flush,
    output div_block, div_done, div_lo, div_hi
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: LO = quotient, HI = remainder.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and finishes in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] sr;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   dividend_raw;
  logic               q_neg;
  logic               r_neg;
  logic               div_zero;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;

  logic               start;
  logic               src1_neg;
  logic               src2_neg;
  logic [WIDTH-1:0]   src1_abs;
  logic [WIDTH-1:0]   src2_abs;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   next_hi;
  logic [WIDTH-1:0]   next_lo;
  logic [WIDTH-1:0]   final_lo;
  logic [WIDTH-1:0]   final_hi;

  assign start    = bus.es_valid & bus.es_div_op & ~bus.ex_flush;
  assign src1_neg = bus.es_div_signed & bus.es_src1[WIDTH-1];
  assign src2_neg = bus.es_div_signed & bus.es_src2[WIDTH-1];
  assign src1_abs = src1_neg ? -bus.es_src1 : bus.es_src1;
  assign src2_abs = src2_neg ? -bus.es_src2 : bus.es_src2;

  // The top bit of sr is the carry that the left shift would push out, so the
  // trial subtraction sees the full WIDTH+1-bit partial remainder.
  assign trial = sr[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};

  always_comb begin
    next_hi = sr[2*WIDTH-2:WIDTH-1];
    next_lo = {sr[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      next_hi = trial[WIDTH-1:0];
      next_lo = {sr[WIDTH-2:0], 1'b1};
    end
  end

  assign final_lo = div_zero ? {WIDTH{1'b1}} : (q_neg ? -next_lo : next_lo);
  assign final_hi = div_zero ? dividend_raw  : (r_neg ? -next_hi : next_hi);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= 6'd0;
      sr           <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_zero     <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
    end else if (bus.ex_flush) begin
      state <= S_IDLE;
      cnt   <= 6'd0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sr           <= {{WIDTH{1'b0}}, src1_abs};
            divisor      <= src2_abs;
            dividend_raw <= bus.es_src1;
            q_neg        <= src1_neg ^ src2_neg;
            r_neg        <= src1_neg;
            div_zero     <= (bus.es_src2 == '0);
            cnt          <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
            if (bus.es_src2 == '0) begin
              state <= S_DONE;
              lo_q  <= {WIDTH{1'b1}};
              hi_q  <= bus.es_src1;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          sr  <= {next_hi, next_lo};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= S_DONE;
            lo_q  <= final_lo;
            hi_q  <= final_hi;
          end
        end
        S_DONE: begin
          if (bus.es_go) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.div_block = resetn & bus.es_valid & bus.es_div_op & (state != S_DONE) & ~bus.ex_flush;
  assign bus.div_done  = (state == S_DONE);
  assign bus.div_lo    = lo_q;
  assign bus.div_hi    = hi_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized DIV/DIVU
// against a plain-arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // MIPS semantics: truncating division, remainder takes the dividend's sign;
  // 64-bit arithmetic absorbs the 0x80000000 / -1 overflow case.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  function automatic int expected_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic drive_idle();
    bus.es_valid      = 1'b0;
    bus.es_div_op     = 1'b0;
    bus.es_div_signed = 1'b0;
    bus.es_src1       = 32'd0;
    bus.es_src2       = 32'd0;
    bus.es_go         = 1'b0;
    bus.ex_flush      = 1'b0;
  endtask

  // Issues one op at the cycle after the next rising edge, measures block/done
  // timing, checks results, optionally holds DONE, then raises es_go.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input string tag);
    logic [31:0] el;
    logic [31:0] eh;
    int blk;
    int cyc;
    int lat;
    model(a, b, sgn, el, eh);
    lat = expected_latency(b);
    @(posedge clk);
    #1;
    bus.es_valid      = 1'b1;
    bus.es_div_op     = 1'b1;
    bus.es_div_signed = sgn;
    bus.es_src1       = a;
    bus.es_src2       = b;
    bus.es_go         = 1'b0;
    bus.ex_flush      = 1'b0;
    blk = 0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (bus.div_done) break;
      if (bus.div_block) blk++;
      cyc++;
    end
    checks++;
    if (cyc !== lat) begin
      failures++;
      $display("[TB] FAIL %s done_cycle: got %0d want %0d", tag, cyc, lat);
    end
    checks++;
    if (blk !== lat) begin
      failures++;
      $display("[TB] FAIL %s block_cycles: got %0d want %0d", tag, blk, lat);
    end
    checks++;
    if (bus.div_block !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s block_in_done: got %b want 0", tag, bus.div_block);
    end
    checks++;
    if (bus.div_lo !== el || bus.div_hi !== eh) begin
      failures++;
      $display("[TB] FAIL %s result: got lo=%h hi=%h want lo=%h hi=%h (a=%h b=%h s=%b)",
               tag, bus.div_lo, bus.div_hi, el, eh, a, b, sgn);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bus.div_done !== 1'b1 || bus.div_lo !== el || bus.div_hi !== eh) begin
        failures++;
        $display("[TB] FAIL %s hold%0d: got done=%b lo=%h hi=%h want done=1 lo=%h hi=%h",
                 tag, h, bus.div_done, bus.div_lo, bus.div_hi, el, eh);
      end
    end
    bus.es_go = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    resetn        = 1'b0;
    bus.es_valid  = 1'b1;
    bus.es_div_op = 1'b1;
    bus.es_src1   = 32'd50;
    bus.es_src2   = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.div_block !== 1'b0 || bus.div_done !== 1'b0 || bus.div_lo !== 32'd0 || bus.div_hi !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got block=%b done=%b lo=%h hi=%h want all 0",
               bus.div_block, bus.div_done, bus.div_lo, bus.div_hi);
    end
    drive_idle();
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
    do_div(-32'sd100, 32'd7, 1'b1, 0, "div_m100_7");
    do_div(32'd100, -32'sd7, 1'b1, 0, "div_100_m7");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_overflow");
    do_div(32'h1234_5678, 32'd0, 1'b0, 0, "divu_zero");
    do_div(32'hF000_0001, 32'd0, 1'b1, 0, "div_zero_neg");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "divu_max_1");
  endtask

  task automatic test_flush();
    @(posedge clk);
    #1;
    bus.es_valid      = 1'b1;
    bus.es_div_op     = 1'b1;
    bus.es_div_signed = 1'b1;
    bus.es_src1       = 32'd1000;
    bus.es_src2       = 32'd3;
    bus.es_go         = 1'b0;
    bus.ex_flush      = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.ex_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_block !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_block: got %b want 0", bus.div_block);
    end
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.div_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_done: got %b want 0", bus.div_done);
    end
    do_div(32'd77, 32'd5, 1'b0, 0, "after_flush");
  endtask

  task automatic test_hold();
    do_div(32'd100, 32'd7, 1'b0, 5, "hold_done");
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.div_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL go_to_idle: got done=%b want 0", bus.div_done);
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk);
    #1;
    bus.es_valid      = 1'b1;
    bus.es_div_op     = 1'b1;
    bus.es_div_signed = 1'b0;
    bus.es_src1       = 32'd12345;
    bus.es_src2       = 32'd17;
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_block !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_gate_block: got %b want 0", bus.div_block);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (bus.div_block !== 1'b0 || bus.div_done !== 1'b0 || bus.div_lo !== 32'd0 || bus.div_hi !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got block=%b done=%b lo=%h hi=%h want all 0",
               bus.div_block, bus.div_done, bus.div_lo, bus.div_hi);
    end
    do_div(32'd9, 32'd3, 1'b0, 0, "divu_9_3");
  endtask

  // Ops are issued back to back: each new DIV sits in ES the cycle after es_go.
  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(a, b, s, 0, "random");
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    $display("[TB] starting div_unit bench");
    test_reset();
    test_directed();
    test_flush();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
